// File: rtl/servo_pkg.sv
// servo_pkg: shared types and byte constants for the CD-i servo command link.
//   cmd_e    : command selector seen on cmd[1:0]
//   disc_e   : decoded disc type presented on disc[1:0]
//   state_e  : servo_cmd_master FSM states
//   cmd_byte : maps a command selector to its opcode byte
//   decode_disc / decode_tray : report byte decoders
package servo_pkg;

  typedef enum logic [1:0] {
    CMD_STATUS = 2'd0,
    CMD_OPEN   = 2'd1,
    CMD_CLOSE  = 2'd2,
    CMD_RSVD   = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    DISC_NONE    = 2'd0,
    DISC_AUDIO   = 2'd1,
    DISC_CDI     = 2'd2,
    DISC_UNKNOWN = 2'd3
  } disc_e;

  typedef enum logic [3:0] {
    ST_SYNC,
    ST_SYNC_WAIT,
    ST_IDLE,
    ST_CMD_TX,
    ST_CMD_ACK,
    ST_RPT_WAIT,
    ST_RPT_TX,
    ST_RPT_ACK,
    ST_FIN_WAIT
  } state_e;

  localparam logic [7:0] BYTE_SYNC        = 8'hDD;
  localparam logic [7:0] BYTE_SYNC_ACK    = 8'hEE;
  localparam logic [7:0] BYTE_CMD_ACK     = 8'h55;
  localparam logic [7:0] BYTE_POLL        = 8'hAA;
  localparam logic [7:0] BYTE_STATUS      = 8'hB0;
  localparam logic [7:0] BYTE_OPEN        = 8'hA6;
  localparam logic [7:0] BYTE_CLOSE       = 8'hA7;
  localparam logic [7:0] BYTE_RPT_LEN     = 8'h03;
  localparam logic [7:0] BYTE_TRAY_OPEN   = 8'h21;
  localparam logic [7:0] BYTE_TRAY_CLOSED = 8'h25;

  function automatic logic [7:0] cmd_byte(input logic [1:0] c);
    logic [7:0] b;
    b = BYTE_STATUS;
    case (cmd_e'(c))
      CMD_OPEN:  b = BYTE_OPEN;
      CMD_CLOSE: b = BYTE_CLOSE;
      default:   b = BYTE_STATUS;
    endcase
    return b;
  endfunction

  function automatic disc_e decode_disc(input logic [7:0] b);
    disc_e d;
    case (b)
      8'h01:   d = DISC_AUDIO;
      8'h02:   d = DISC_CDI;
      8'h03:   d = DISC_NONE;
      default: d = DISC_UNKNOWN;
    endcase
    return d;
  endfunction

  // Only the explicit open code reports an open tray; closed and any
  // unrecognised value both read as closed.
  function automatic logic decode_tray(input logic [7:0] b);
    logic t;
    case (b)
      BYTE_TRAY_OPEN:   t = 1'b1;
      BYTE_TRAY_CLOSED: t = 1'b0;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/parallelel_spi.sv
// parallelel_spi: byte-parallel SPI-style link between the slave MCU and
// the servo.
//   write     : 1-cycle strobe from the master
//   mosi[7:0] : byte from master, valid while write is high
//   miso[7:0] : byte from servo, sampled by the master in the write cycle
interface parallelel_spi;
  logic       write;
  logic [7:0] mosi;
  logic [7:0] miso;

  modport master (output write, output mosi, input miso);
  modport slave  (input write, input mosi, output miso);
endinterface

// File: rtl/servo_fault_timer.sv
// servo_fault_timer: loadable down-counter with clear and expired flag.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val (wins over clear)
//   clear        : force count to zero
//   load_val     : value loaded on load
//   expired      : count is zero
// The counter decrements every cycle and holds at zero.
module servo_fault_timer #(
  parameter int FAULT_TIMEOUT = 4096,
  localparam int W = $clog2(FAULT_TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clear) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/servo_cmd_master.sv
// servo_cmd_master: initiator of the slave-MCU <-> servo byte link.
// Syncs with 0xDD/0xEE, sends status/open/close command frames, polls the
// 5-byte disc-state report and presents decoded disc and tray status.
//   clk, reset_n   : clock, asynchronous active-low reset
//   spi            : parallelel_spi master modport
//   mode_fault     : byte-acknowledge / report-ready pulse from servo
//   cmd_valid, cmd : command request (0 STATUS, 1 OPEN, 2 CLOSE, 3 ignored)
//   cmd_ready      : high only in IDLE
//   status_valid   : 1-cycle pulse when a report has been decoded
//   disc, tray_open: decoded report contents
//   err            : sticky error, cleared by the next accepted command
//   synced         : link sync achieved
// Build option: SERVO_MASTER_UNSOLICITED_EN lets a mode_fault pulse in IDLE
// start a report read directly (servo pushes a report on disc mount).
//
// state     | meaning
// SYNC      | write 0xDD, check for 0xEE
// SYNC_WAIT | back-off SYNC_GAP cycles before retrying sync
// IDLE      | synced, waiting for a command
// CMD_TX    | command byte i write cycle
// CMD_ACK   | waiting for mode_fault acknowledging command byte i
// RPT_WAIT  | waiting for mode_fault signalling report ready
// RPT_TX    | report byte j write cycle (0xAA poll)
// RPT_ACK   | waiting for mode_fault acknowledging report byte j
// FIN_WAIT  | report decoded, waiting for final mode_fault
module servo_cmd_master
  import servo_pkg::*;
#(
  parameter int SYNC_GAP      = 64,
  parameter int FAULT_TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  parallelel_spi.master spi,
  input  logic          mode_fault,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd,
  output logic          cmd_ready,
  output logic          status_valid,
  output disc_e         disc,
  output logic          tray_open,
  output logic          err,
  output logic          synced
);

  localparam int W = $clog2(FAULT_TIMEOUT + 1);
  localparam logic [W-1:0] GAP_LOAD = W'(SYNC_GAP - 1);
  localparam logic [W-1:0] TMO_LOAD = W'(FAULT_TIMEOUT - 1);

  state_e     state, next_state;
  logic       write_q, write_d;
  logic [7:0] mosi_q, mosi_d;
  logic [2:0] idx, idx_d;
  logic [7:0] disc_byte, disc_byte_d;
  disc_e      disc_d;
  logic       tray_d, sv_d, err_d, synced_d;

  logic         tmr_load, tmr_clear, tmr_expired;
  logic [W-1:0] tmr_load_val;

  function automatic logic is_timed(input state_e s);
    return (s == ST_SYNC_WAIT) || (s == ST_CMD_ACK) || (s == ST_RPT_WAIT) ||
           (s == ST_RPT_ACK)   || (s == ST_FIN_WAIT);
  endfunction

  assign spi.write = write_q;
  assign spi.mosi  = mosi_q;
  assign cmd_ready = (state == ST_IDLE);

  // Every entry into a waiting state restarts the timer; SYNC_WAIT reuses it
  // for the retry back-off.
  assign tmr_load     = is_timed(next_state) && (next_state != state);
  assign tmr_clear    = !is_timed(next_state);
  assign tmr_load_val = (next_state == ST_SYNC_WAIT) ? GAP_LOAD : TMO_LOAD;

  servo_fault_timer #(.FAULT_TIMEOUT(FAULT_TIMEOUT)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .clear    (tmr_clear),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_SYNC;
    else          state <= next_state;
  end

  // write_d/mosi_d describe the byte for the cycle in which next_state is a
  // write state, so the strobe comes straight out of a flop. The accepted
  // command opcode is captured directly into mosi.
  always_comb begin
    next_state  = state;
    write_d     = 1'b0;
    mosi_d      = mosi_q;
    idx_d       = idx;
    disc_byte_d = disc_byte;
    disc_d      = disc;
    tray_d      = tray_open;
    sv_d        = 1'b0;
    err_d       = err;
    synced_d    = synced;

    case (state)
      ST_SYNC: begin
        if (write_q) begin
          if (spi.miso == BYTE_SYNC_ACK) begin
            next_state = ST_IDLE;
            synced_d   = 1'b1;
          end else begin
            next_state = ST_SYNC_WAIT;
          end
        end else begin
          // first cycle out of reset: issue the sync write next
          write_d = 1'b1;
          mosi_d  = BYTE_SYNC;
        end
      end

      ST_SYNC_WAIT: begin
        if (tmr_expired) begin
          next_state = ST_SYNC;
          write_d    = 1'b1;
          mosi_d     = BYTE_SYNC;
        end
      end

      ST_IDLE: begin
`ifdef SERVO_MASTER_UNSOLICITED_EN
        if (mode_fault) begin
          next_state = ST_RPT_TX;
          idx_d      = '0;
          write_d    = 1'b1;
          mosi_d     = BYTE_POLL;
        end else
`endif
        if (cmd_valid && (cmd != CMD_RSVD)) begin
          next_state = ST_CMD_TX;
          idx_d      = '0;
          err_d      = 1'b0;
          write_d    = 1'b1;
          mosi_d     = cmd_byte(cmd);
        end
      end

      ST_CMD_TX: begin
        next_state = ST_CMD_ACK;
        if ((idx == 3'd0) && (spi.miso != BYTE_CMD_ACK)) err_d = 1'b1;
      end

      ST_CMD_ACK: begin
        if (mode_fault) begin
          if (idx == 3'd3) begin
            next_state = ST_RPT_WAIT;
          end else begin
            next_state = ST_CMD_TX;
            idx_d      = idx + 3'd1;
            write_d    = 1'b1;
            mosi_d     = 8'h00;
          end
        end else if (tmr_expired) begin
          next_state = ST_SYNC;
        end
      end

      ST_RPT_WAIT: begin
        if (mode_fault) begin
          next_state = ST_RPT_TX;
          idx_d      = '0;
          write_d    = 1'b1;
          mosi_d     = BYTE_POLL;
        end else if (tmr_expired) begin
          next_state = ST_SYNC;
        end
      end

      ST_RPT_TX: begin
        next_state = ST_RPT_ACK;
        case (idx)
          3'd0: if (spi.miso != BYTE_RPT_LEN) err_d = 1'b1;
          3'd1: if (spi.miso != BYTE_STATUS)  err_d = 1'b1;
          3'd2: if (spi.miso != 8'h00)        err_d = 1'b1;
          3'd3: disc_byte_d = spi.miso;
          default: begin
            next_state = ST_FIN_WAIT;
            disc_d     = decode_disc(disc_byte);
            tray_d     = decode_tray(spi.miso);
            sv_d       = 1'b1;
          end
        endcase
      end

      ST_RPT_ACK: begin
        if (mode_fault) begin
          next_state = ST_RPT_TX;
          idx_d      = idx + 3'd1;
          write_d    = 1'b1;
          mosi_d     = BYTE_POLL;
        end else if (tmr_expired) begin
          next_state = ST_SYNC;
        end
      end

      ST_FIN_WAIT: begin
        if (mode_fault)       next_state = ST_IDLE;
        else if (tmr_expired) next_state = ST_SYNC;
      end

      default: next_state = ST_SYNC;
    endcase

    // Timeout out of any acknowledge/wait state drops sync and retries at once.
    if ((state != ST_SYNC_WAIT) && is_timed(state) && (next_state == ST_SYNC)) begin
      err_d    = 1'b1;
      synced_d = 1'b0;
      write_d  = 1'b1;
      mosi_d   = BYTE_SYNC;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q      <= 1'b0;
      mosi_q       <= 8'hFF;
      idx          <= '0;
      disc_byte    <= '0;
      disc         <= DISC_NONE;
      tray_open    <= 1'b0;
      status_valid <= 1'b0;
      err          <= 1'b0;
      synced       <= 1'b0;
    end else begin
      write_q      <= write_d;
      mosi_q       <= mosi_d;
      idx          <= idx_d;
      disc_byte    <= disc_byte_d;
      disc         <= disc_d;
      tray_open    <= tray_d;
      status_valid <= sv_d;
      err          <= err_d;
      synced       <= synced_d;
    end
  end

endmodule
